// File: rtl/ddr5_bank_sequencer.sv
`default_nettype none
// ======================================================================
// ddr5_bank_sequencer : single-bank ACT -> RD/WR -> PRE command sequencer
// Optional macro OPEN_PAGE_EN keeps the row open for same-row hits.
// Revision 1.0
// ======================================================================
module ddr5_bank_sequencer #(
  parameter int T_RCD      = 76,
  parameter int T_RAS      = 152,
  parameter int T_RC       = 228,
  parameter int T_RP       = 76,
  parameter int T_RTP      = 36,
  parameter int T_CWD      = 76,
  parameter int T_BURST    = 16,
  parameter int T_WR       = 60,
`ifdef OPEN_PAGE_EN
  parameter int T_CCD_L    = 22,
  parameter int T_CCD_L_WR = 94,
`endif
  parameter int CNT_W      = 9
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_bg,
  input  logic [1:0]  req_bank,
  input  logic [15:0] req_row,
  input  logic [9:0]  req_col,
  output logic        cmd_valid,
  output logic [1:0]  cmd_type,
  output logic [2:0]  cmd_bg,
  output logic [1:0]  cmd_bank,
  output logic [15:0] cmd_addr,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ACT      = 3'd1,
    S_WAIT_RCD = 3'd2,
    S_COL      = 3'd3,
    S_WAIT_PRE = 3'd4,
    S_PRE      = 3'd5
`ifdef OPEN_PAGE_EN
    , S_OPEN   = 3'd6
`endif
  } state_t;

  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] LD_RCD = CNT_W'(T_RCD - 1);
  localparam logic [CNT_W-1:0] LD_RAS = CNT_W'(T_RAS - 1);
  localparam logic [CNT_W-1:0] LD_RC  = CNT_W'(T_RC - 1);
  localparam logic [CNT_W-1:0] LD_RP  = CNT_W'(T_RP - 1);
  localparam logic [CNT_W-1:0] LD_RTP = CNT_W'(T_RTP - 1);
  localparam logic [CNT_W-1:0] LD_WRP = CNT_W'(T_CWD + T_BURST + T_WR - 1);
`ifdef OPEN_PAGE_EN
  localparam logic [CNT_W-1:0] LD_CCD_RD = CNT_W'(T_CCD_L - 1);
  localparam logic [CNT_W-1:0] LD_CCD_WR = CNT_W'(T_CCD_L_WR - 1);
`endif

  function automatic logic [CNT_W-1:0] dec(input logic [CNT_W-1:0] v);
    return (v == '0) ? '0 : v - ONE;
  endfunction

  state_t            state_q, state_d;
  logic              rdy_en_q;
  logic              wr_q;
  logic [2:0]        bg_q, cur_bg_q;
  logic [1:0]        bank_q, cur_bank_q;
  logic [15:0]       row_q, cur_row_q;
  logic [9:0]        col_q;
  logic [CNT_W-1:0]  rcd_q, ras_q, rc_q, rp_q, pre_q;

  logic              accept, act_ok, gate_lat;
  logic              do_act, do_col, do_pre, latch;
  logic [2:0]        act_bg;
  logic [1:0]        act_bank;
  logic [15:0]       act_row;
  logic              col_wr;
  logic [9:0]        col_addr;

`ifdef OPEN_PAGE_EN
  logic              pend_q, pend_d, has_col_q, last_wr_q;
  logic [CNT_W-1:0]  ccd_rd_q, ccd_wr_q;
  logic              gate_req, hit;

  // Same-type column pairs use tCCD_L; mixed pairs wait out the pre-delay.
  assign gate_lat = (rcd_q == '0) && (!has_col_q ||
                    ((wr_q == last_wr_q) ? (wr_q ? (ccd_wr_q == '0) : (ccd_rd_q == '0))
                                         : (pre_q == '0)));
  assign gate_req = (rcd_q == '0) && (!has_col_q ||
                    ((req_write == last_wr_q) ? (req_write ? (ccd_wr_q == '0) : (ccd_rd_q == '0))
                                              : (pre_q == '0)));
  assign hit      = (req_bg == cur_bg_q) && (req_bank == cur_bank_q) && (req_row == cur_row_q);
`else
  assign gate_lat = (rcd_q == '0);
`endif

  assign act_ok = (rp_q == '0) && (rc_q == '0);
  assign accept = req_valid && req_ready;

  always_comb begin
    req_ready = 1'b0;
    if (rdy_en_q) begin
      case (state_q)
        S_IDLE:  req_ready = act_ok;
`ifdef OPEN_PAGE_EN
        S_OPEN:  req_ready = 1'b1;
`endif
        default: req_ready = 1'b0;
      endcase
    end
  end

  always_comb begin
    state_d  = state_q;
    do_act   = 1'b0;
    do_col   = 1'b0;
    do_pre   = 1'b0;
    latch    = 1'b0;
    act_bg   = bg_q;
    act_bank = bank_q;
    act_row  = row_q;
    col_wr   = wr_q;
    col_addr = col_q;
`ifdef OPEN_PAGE_EN
    pend_d   = pend_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          latch    = 1'b1;
          do_act   = 1'b1;
          act_bg   = req_bg;
          act_bank = req_bank;
          act_row  = req_row;
          state_d  = S_ACT;
        end
      end
      S_ACT, S_WAIT_RCD: begin
        if (gate_lat) begin
          do_col  = 1'b1;
          state_d = S_COL;
        end else begin
          state_d = S_WAIT_RCD;
        end
      end
      S_COL: begin
`ifdef OPEN_PAGE_EN
        state_d = S_OPEN;
`else
        state_d = S_WAIT_PRE;
`endif
      end
      S_WAIT_PRE: begin
        if ((ras_q == '0) && (pre_q == '0)) begin
          do_pre  = 1'b1;
          state_d = S_PRE;
        end
      end
      S_PRE: begin
`ifdef OPEN_PAGE_EN
        // A pending miss re-activates straight from here once tRP/tRC allow.
        if (pend_q) begin
          if (act_ok) begin
            do_act  = 1'b1;
            pend_d  = 1'b0;
            state_d = S_ACT;
          end
        end else begin
          state_d = S_IDLE;
        end
`else
        state_d = S_IDLE;
`endif
      end
`ifdef OPEN_PAGE_EN
      S_OPEN: begin
        if (accept) begin
          latch = 1'b1;
          if (hit) begin
            if (gate_req) begin
              do_col   = 1'b1;
              col_wr   = req_write;
              col_addr = req_col;
              state_d  = S_COL;
            end else begin
              state_d  = S_WAIT_RCD;
            end
          end else begin
            pend_d  = 1'b1;
            state_d = S_WAIT_PRE;
          end
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      rdy_en_q   <= 1'b0;
      busy       <= 1'b0;
      wr_q       <= 1'b0;
      bg_q       <= '0;
      bank_q     <= '0;
      row_q      <= '0;
      col_q      <= '0;
      cur_bg_q   <= '0;
      cur_bank_q <= '0;
      cur_row_q  <= '0;
      rcd_q      <= '0;
      ras_q      <= '0;
      rc_q       <= '0;
      rp_q       <= '0;
      pre_q      <= '0;
      cmd_valid  <= 1'b0;
      cmd_type   <= '0;
      cmd_bg     <= '0;
      cmd_bank   <= '0;
      cmd_addr   <= '0;
`ifdef OPEN_PAGE_EN
      pend_q     <= 1'b0;
      has_col_q  <= 1'b0;
      last_wr_q  <= 1'b0;
      ccd_rd_q   <= '0;
      ccd_wr_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      rdy_en_q <= 1'b1;
      busy     <= (state_d != S_IDLE);
      if (latch) begin
        wr_q   <= req_write;
        bg_q   <= req_bg;
        bank_q <= req_bank;
        row_q  <= req_row;
        col_q  <= req_col;
      end
      if (do_act) begin
        cur_bg_q   <= act_bg;
        cur_bank_q <= act_bank;
        cur_row_q  <= act_row;
      end
      rcd_q <= do_act ? LD_RCD : dec(rcd_q);
      ras_q <= do_act ? LD_RAS : dec(ras_q);
      rc_q  <= do_act ? LD_RC  : dec(rc_q);
      rp_q  <= do_pre ? LD_RP  : dec(rp_q);
      pre_q <= do_col ? (col_wr ? LD_WRP : LD_RTP) : dec(pre_q);
`ifdef OPEN_PAGE_EN
      pend_q   <= pend_d;
      ccd_rd_q <= (do_col && !col_wr) ? LD_CCD_RD : dec(ccd_rd_q);
      ccd_wr_q <= (do_col &&  col_wr) ? LD_CCD_WR : dec(ccd_wr_q);
      if (do_act) begin
        has_col_q <= 1'b0;
      end else if (do_col) begin
        has_col_q <= 1'b1;
        last_wr_q <= col_wr;
      end
`endif
      cmd_valid <= do_act | do_col | do_pre;
      if (do_act) begin
        cmd_type <= 2'd0;
        cmd_bg   <= act_bg;
        cmd_bank <= act_bank;
        cmd_addr <= act_row;
      end else if (do_col) begin
        cmd_type <= col_wr ? 2'd2 : 2'd1;
        cmd_bg   <= cur_bg_q;
        cmd_bank <= cur_bank_q;
        cmd_addr <= {6'd0, col_addr};
      end else if (do_pre) begin
        cmd_type <= 2'd3;
        cmd_bg   <= cur_bg_q;
        cmd_bank <= cur_bank_q;
        cmd_addr <= cur_row_q;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ddr5_bank_sequencer.sv
`default_nettype none
// ======================================================================
// tb_ddr5_bank_sequencer : directed self-checking bench for the sequencer
// Revision 1.0
// ======================================================================
module tb_ddr5_bank_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [2:0]  req_bg = '0;
  logic [1:0]  req_bank = '0;
  logic [15:0] req_row = '0;
  logic [9:0]  req_col = '0;
  logic        req_ready;
  logic        cmd_valid;
  logic [1:0]  cmd_type;
  logic [2:0]  cmd_bg;
  logic [1:0]  cmd_bank;
  logic [15:0] cmd_addr;
  logic        busy;

  ddr5_bank_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_bg    (req_bg),
    .req_bank  (req_bank),
    .req_row   (req_row),
    .req_col   (req_col),
    .cmd_valid (cmd_valid),
    .cmd_type  (cmd_type),
    .cmd_bg    (cmd_bg),
    .cmd_bank  (cmd_bank),
    .cmd_addr  (cmd_addr),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int cyc  = 0;
  int base = 0;
  int nvec = 0;
  int nerr = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int t;
    int ty;
    int addr;
    int bg;
    int bank;
  } ev_t;

  ev_t evq[$];
  ev_t mon_e;

  // Command log, time-stamped relative to the current accept cycle.
  always @(negedge clk) begin
    if (rst_n && cmd_valid) begin
      mon_e.t    = cyc - base;
      mon_e.ty   = int'(cmd_type);
      mon_e.addr = int'(cmd_addr);
      mon_e.bg   = int'(cmd_bg);
      mon_e.bank = int'(cmd_bank);
      evq.push_back(mon_e);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_ev(input string tag, input int idx, input int t, input int ty, input int addr);
    if (idx < evq.size()) begin
      check({tag, "_cyc"},  evq[idx].t,    t);
      check({tag, "_type"}, evq[idx].ty,   ty);
      check({tag, "_addr"}, evq[idx].addr, addr);
    end else begin
      check({tag, "_present"}, evq.size(), idx + 1);
    end
  endtask

  task automatic wait_rel(input int n);
    do @(negedge clk); while ((cyc - base) < n);
  endtask

  task automatic req(input logic wr, input logic [2:0] bg, input logic [1:0] bk,
                     input logic [15:0] row, input logic [9:0] col, input logic hold,
                     output int at);
    int n;
    n = 0;
    @(posedge clk);
    #1;
    req_valid = 1'b1;
    req_write = wr;
    req_bg    = bg;
    req_bank  = bk;
    req_row   = row;
    req_col   = col;
    do begin
      @(negedge clk);
      n++;
    end while (!req_ready && n < 1000);
    if (!req_ready) check("req_accept_timeout", 32'd0, 32'd1);
    at = cyc;
    @(posedge clk);
    #1;
    if (!hold) req_valid = 1'b0;
  endtask

  task automatic pulse_reset(output int rel);
    @(posedge clk);
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    rel = cyc;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, nerr=%0d", nerr);
    $fatal(1, "watchdog");
  end

  initial begin
    int t, t2, rel;

    // Reset state and the one-cycle ready hold-off after release
    repeat (2) @(posedge clk);
    #1;
    check("rst_cmd_valid", cmd_valid, 1'b0);
    check("rst_busy",      busy,      1'b0);
    check("rst_ready",     req_ready, 1'b0);
    check("rst_cmd_addr",  cmd_addr,  16'h0000);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_first_cycle", req_ready, 1'b0);
    @(negedge clk);
    check("ready_second_cycle", req_ready, 1'b1);

`ifndef OPEN_PAGE_EN
    // Single read: ACT@1, RD@77, PRE@153, ready@228
    evq.delete();
    req(1'b0, 3'd1, 2'd1, 16'h1234, 10'h155, 1'b0, t);
    base = t;
    wait_rel(100);
    check("rd_busy_mid", busy, 1'b1);
    wait_rel(227);
    check("rd_ready_227", req_ready, 1'b0);
    wait_rel(228);
    check("rd_ready_228", req_ready, 1'b1);
    wait_rel(229);
    check("rd_busy_229", busy, 1'b0);
    check("rd_ncmd", evq.size(), 3);
    check_ev("rd_act", 0, 1, 0, 16'h1234);
    check_ev("rd_rd",  1, 77, 1, 16'h0155);
    check_ev("rd_pre", 2, 153, 3, 16'h1234);
    if (evq.size() > 0) begin
      check("rd_act_bg",   evq[0].bg,   1);
      check("rd_act_bank", evq[0].bank, 1);
    end

    // Single write: PRE@229 (77+76+16+60), ready@304
    evq.delete();
    req(1'b1, 3'd5, 2'd2, 16'hBEEF, 10'h3FF, 1'b0, t);
    base = t;
    wait_rel(303);
    check("wr_ready_303", req_ready, 1'b0);
    wait_rel(304);
    check("wr_ready_304", req_ready, 1'b1);
    check("wr_ncmd", evq.size(), 3);
    check_ev("wr_act", 0, 1, 0, 16'hBEEF);
    check_ev("wr_wr",  1, 77, 2, 16'h03FF);
    check_ev("wr_pre", 2, 229, 3, 16'hBEEF);

    // Back-to-back reads with req_valid held: second ACT exactly @229
    evq.delete();
    req(1'b0, 3'd0, 2'd0, 16'h0A0A, 10'h001, 1'b1, t);
    base = t;
    req_row = 16'h0B0B;
    req_col = 10'h002;
    wait_rel(228);
    check("b2b_ready_228", req_ready, 1'b1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    wait_rel(460);
    check("b2b_ncmd", evq.size(), 6);
    check_ev("b2b_pre1", 2, 153, 3, 16'h0A0A);
    check_ev("b2b_act2", 3, 229, 0, 16'h0B0B);
    check_ev("b2b_rd2",  4, 305, 1, 16'h0002);
    check_ev("b2b_pre2", 5, 381, 3, 16'h0B0B);

    // Reset at cycle 100 of a write: outputs clear at once, no PRE afterwards
    evq.delete();
    req(1'b1, 3'd2, 2'd3, 16'h5555, 10'h0AA, 1'b0, t);
    base = t;
    wait_rel(100);
    #2 rst_n = 1'b0;
    #1;
    check("arst_cmd_valid", cmd_valid, 1'b0);
    check("arst_cmd_type",  cmd_type,  2'd0);
    check("arst_cmd_addr",  cmd_addr,  16'h0000);
    check("arst_cmd_bg",    cmd_bg,    3'd0);
    check("arst_busy",      busy,      1'b0);
    check("arst_ready",     req_ready, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    rel = cyc;
    check("arst_ncmd_before", evq.size(), 2);
    evq.delete();
    req(1'b0, 3'd4, 2'd1, 16'h0777, 10'h011, 1'b0, t);
    check("arst_accept_delay", t - rel, 1);
    base = t;
    wait_rel(230);
    check("arst_ncmd_after", evq.size(), 3);
    check_ev("arst_act", 0, 1, 0, 16'h0777);
    check_ev("arst_rd",  1, 77, 1, 16'h0011);
    check_ev("arst_pre", 2, 153, 3, 16'h0777);
`else
    // Open page, same-row hit presented @78: RD@77, RD@99, nothing in between
    pulse_reset(rel);
    evq.delete();
    req(1'b0, 3'd1, 2'd0, 16'h00AA, 10'h010, 1'b0, t);
    base = t;
    wait_rel(77);
    req(1'b0, 3'd1, 2'd0, 16'h00AA, 10'h020, 1'b0, t2);
    check("hit_accept_cyc", t2 - base, 78);
    wait_rel(140);
    check("hit_ncmd", evq.size(), 3);
    check_ev("hit_act", 0, 1, 0, 16'h00AA);
    check_ev("hit_rd1", 1, 77, 1, 16'h0010);
    check_ev("hit_rd2", 2, 99, 1, 16'h0020);

    // Open page, row miss: PRE@153, ACT@229, RD@305
    pulse_reset(rel);
    evq.delete();
    req(1'b0, 3'd1, 2'd0, 16'h00AA, 10'h010, 1'b0, t);
    base = t;
    wait_rel(77);
    req(1'b0, 3'd1, 2'd0, 16'h00BB, 10'h030, 1'b0, t2);
    check("miss_accept_cyc", t2 - base, 78);
    wait_rel(310);
    check("miss_ncmd", evq.size(), 5);
    check_ev("miss_act1", 0, 1, 0, 16'h00AA);
    check_ev("miss_rd1",  1, 77, 1, 16'h0010);
    check_ev("miss_pre",  2, 153, 3, 16'h00AA);
    check_ev("miss_act2", 3, 229, 0, 16'h00BB);
    check_ev("miss_rd2",  4, 305, 1, 16'h0030);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
`default_nettype wire
